// File: rtl/vec_cache_wdb_entry_alloc_if.sv
// Shared vector-cache widths and the allocate/release bundle between the WDB
// entry allocator (master) and the write request crossbar (slave).
package vector_cache_pkg;
  localparam int DB_ENTRY_IDX_WIDTH = 6;
endpackage

interface vec_cache_wdb_entry_alloc_if #(
  parameter int IDX_W = vector_cache_pkg::DB_ENTRY_IDX_WIDTH
);
  logic [3:0]            alloc_vld;
  logic [3:0][IDX_W-1:0] alloc_idx;
  logic [3:0]            alloc_rdy;
  logic [3:0]            rel_vld;
  logic [3:0][IDX_W-1:0] rel_idx;

  modport master (
    output alloc_vld, alloc_idx,
    input  alloc_rdy, rel_vld, rel_idx
  );

  modport slave (
    input  alloc_vld, alloc_idx,
    output alloc_rdy, rel_vld, rel_idx
  );
endinterface

// File: rtl/vec_cache_wdb_entry_alloc.sv
// WDB entry allocator: four independent per-channel free maps, each keeping one
// free entry pre-reserved in a registered output slot and taking entries back on release.
module vec_cache_wdb_entry_alloc
  import vector_cache_pkg::*;
#(
  parameter int  DB_ENTRY_NUM = 64,
  localparam int E            = DB_ENTRY_NUM / 4,
  localparam int LW           = $clog2(E),
  localparam int IDX_W        = DB_ENTRY_IDX_WIDTH,
  localparam int CNT_W        = $clog2(E + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  vec_cache_wdb_entry_alloc_if.master alloc_if,
  output logic [3:0][CNT_W-1:0]     free_cnt,
  output logic [3:0]                err_illegal_rel
);

  logic [3:0][E-1:0]     free_q, free_d;
  logic [3:0]            vld_q, vld_d;
  logic [3:0][IDX_W-1:0] idx_q, idx_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            err_q, err_d;

  logic [3:0][LW-1:0]    pick;
  logic [3:0]            found;
  logic [3:0]            loadable;
  logic [3:0][LW-1:0]    rel_loc;
  logic [3:0]            rel_legal;

  // Reserve looks only at the registered map, so an entry released this cycle
  // cannot be handed out before the next one; the two never touch the same bit.
  always_comb begin
    free_d    = free_q;
    vld_d     = vld_q;
    idx_d     = idx_q;
    err_d     = err_q;
    cnt_d     = '0;
    pick      = '0;
    found     = '0;
    loadable  = '0;
    rel_loc   = '0;
    rel_legal = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = E - 1; i >= 0; i--) begin
        if (free_q[c][i]) begin
          pick[c]  = LW'(i);
          found[c] = 1'b1;
        end
      end
      loadable[c] = !vld_q[c] || alloc_if.alloc_rdy[c];
      if (loadable[c]) begin
        vld_d[c] = found[c];
        if (found[c]) begin
          free_d[c][pick[c]] = 1'b0;
          idx_d[c]           = {2'(c), pick[c]};
        end
      end

      rel_loc[c]   = alloc_if.rel_idx[c][LW-1:0];
      rel_legal[c] = (alloc_if.rel_idx[c][IDX_W-1 -: 2] == 2'(c)) &&
                     !free_q[c][rel_loc[c]] &&
                     !(vld_q[c] && (alloc_if.rel_idx[c] == idx_q[c]));
      if (alloc_if.rel_vld[c]) begin
        if (rel_legal[c]) begin
          free_d[c][rel_loc[c]] = 1'b1;
        end else begin
          err_d[c] = 1'b1;
        end
      end

      for (int i = 0; i < E; i++) begin
        cnt_d[c] = cnt_d[c] + CNT_W'(free_d[c][i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_q <= '1;
      vld_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= {4{CNT_W'(E)}};
      err_q  <= '0;
    end else begin
      free_q <= free_d;
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign alloc_if.alloc_vld = vld_q;
  assign alloc_if.alloc_idx = idx_q;
  assign free_cnt           = cnt_q;
  assign err_illegal_rel    = err_q;

endmodule

// File: tb/tb_vec_cache_wdb_entry_alloc.sv
// Directed bench for the WDB entry allocator: a free-list model compared every
// cycle, plus hand-computed literal checks at the interesting points.
module tb_vec_cache_wdb_entry_alloc;
  localparam int E     = 16;
  localparam int IDX_W = 6;
  localparam int CNT_W = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [3:0][CNT_W-1:0] free_cnt;
  logic [3:0]            err_illegal_rel;

  vec_cache_wdb_entry_alloc_if #(.IDX_W(IDX_W)) bus ();

  vec_cache_wdb_entry_alloc #(.DB_ENTRY_NUM(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_if        (bus),
    .free_cnt        (free_cnt),
    .err_illegal_rel (err_illegal_rel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: each channel is a pool of free global indices; reserve takes the
  // smallest one, release puts the index back, count is the pool size.
  int m_free[4][$];
  bit m_vld[4];
  int m_idx[4];
  bit m_err[4];
  bit model_on = 1'b0;

  function automatic bit in_pool(input int c, input int g);
    for (int k = 0; k < m_free[c].size(); k++) begin
      if (m_free[c][k] == g) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_on = 1'b1;
      for (int c = 0; c < 4; c++) begin
        m_free[c].delete();
        for (int i = 0; i < E; i++) m_free[c].push_back(c * E + i);
        m_vld[c] = 1'b0;
        m_idx[c] = 0;
        m_err[c] = 1'b0;
      end
    end else if (model_on) begin
      for (int c = 0; c < 4; c++) begin
        int r;
        int pos;
        bit legal;
        r     = int'(bus.rel_idx[c]);
        legal = (r >= c * E) && (r < c * E + E) && !in_pool(c, r) &&
                !(m_vld[c] && r == m_idx[c]);
        if (!m_vld[c] || bus.alloc_rdy[c]) begin
          if (m_free[c].size() == 0) begin
            m_vld[c] = 1'b0;
          end else begin
            pos = 0;
            for (int k = 1; k < m_free[c].size(); k++) begin
              if (m_free[c][k] < m_free[c][pos]) pos = k;
            end
            m_idx[c] = m_free[c][pos];
            m_free[c].delete(pos);
            m_vld[c] = 1'b1;
          end
        end
        if (bus.rel_vld[c]) begin
          if (legal) m_free[c].push_back(r);
          else       m_err[c] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int c = 0; c < 4; c++) begin
        checkOutput($sformatf("model alloc_vld[%0d]", c), int'(bus.alloc_vld[c]), int'(m_vld[c]));
        if (m_vld[c])
          checkOutput($sformatf("model alloc_idx[%0d]", c), int'(bus.alloc_idx[c]), m_idx[c]);
        checkOutput($sformatf("model free_cnt[%0d]", c), int'(free_cnt[c]), m_free[c].size());
        checkOutput($sformatf("model err[%0d]", c), int'(err_illegal_rel[c]), int'(m_err[c]));
      end
    end
  end

  // Drive one cycle of inputs, then return just after the edge that samples them.
  task automatic applyStimulus(input logic r, input logic [3:0] rdy, input logic [3:0] rv,
                               input int ri0, input int ri1, input int ri2, input int ri3);
    rst           = r;
    bus.alloc_rdy = rdy;
    bus.rel_vld   = rv;
    bus.rel_idx[0] = IDX_W'(ri0);
    bus.rel_idx[1] = IDX_W'(ri1);
    bus.rel_idx[2] = IDX_W'(ri2);
    bus.rel_idx[3] = IDX_W'(ri3);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllReset(input string tag);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("%s vld[%0d]", tag, c), int'(bus.alloc_vld[c]), 0);
      checkOutput($sformatf("%s idx[%0d]", tag, c), int'(bus.alloc_idx[c]), 0);
      checkOutput($sformatf("%s cnt[%0d]", tag, c), int'(free_cnt[c]), 16);
      checkOutput($sformatf("%s err[%0d]", tag, c), int'(err_illegal_rel[c]), 0);
    end
  endtask

  task automatic checkAllFresh(input string tag);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("%s vld[%0d]", tag, c), int'(bus.alloc_vld[c]), 1);
      checkOutput($sformatf("%s idx[%0d]", tag, c), int'(bus.alloc_idx[c]), 16 * c);
      checkOutput($sformatf("%s cnt[%0d]", tag, c), int'(free_cnt[c]), 15);
    end
  endtask

  initial begin
    // Reset for two cycles, then idle with no consumer.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    checkAllReset("reset");
    applyStimulus(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    checkAllFresh("first load");
    applyStimulus(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    checkAllFresh("idle hold");

    // Drain channel 0 with back-to-back handshakes.
    for (int j = 0; j < 16; j++) begin
      checkOutput($sformatf("drain idx0 step %0d", j), int'(bus.alloc_idx[0]), j);
      checkOutput($sformatf("drain vld0 step %0d", j), int'(bus.alloc_vld[0]), 1);
      applyStimulus(1'b0, 4'b0001, 4'b0000, 0, 0, 0, 0);
    end
    checkOutput("drained vld0", int'(bus.alloc_vld[0]), 0);
    checkOutput("drained cnt0", int'(free_cnt[0]), 0);
    checkOutput("drain other idx1", int'(bus.alloc_idx[1]), 16);
    checkOutput("drain other cnt1", int'(free_cnt[1]), 15);

    // Refill channel 0 by releasing entry 5.
    applyStimulus(1'b0, 4'b0000, 4'b0001, 5, 0, 0, 0);
    checkOutput("refill t+1 cnt0", int'(free_cnt[0]), 1);
    checkOutput("refill t+1 vld0", int'(bus.alloc_vld[0]), 0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    checkOutput("refill t+2 vld0", int'(bus.alloc_vld[0]), 1);
    checkOutput("refill t+2 idx0", int'(bus.alloc_idx[0]), 5);
    checkOutput("refill t+2 cnt0", int'(free_cnt[0]), 0);

    // Channel 1: drain, then build "output 16, only 17 free".
    for (int j = 0; j < 16; j++) applyStimulus(1'b0, 4'b0010, 4'b0000, 0, 0, 0, 0);
    checkOutput("ch1 drained vld1", int'(bus.alloc_vld[1]), 0);
    checkOutput("ch1 drained cnt1", int'(free_cnt[1]), 0);
    applyStimulus(1'b0, 4'b0000, 4'b0010, 0, 16, 0, 0);
    checkOutput("ch1 rel16 cnt1", int'(free_cnt[1]), 1);
    applyStimulus(1'b0, 4'b0000, 4'b0010, 0, 17, 0, 0);
    checkOutput("ch1 setup vld1", int'(bus.alloc_vld[1]), 1);
    checkOutput("ch1 setup idx1", int'(bus.alloc_idx[1]), 16);
    checkOutput("ch1 setup cnt1", int'(free_cnt[1]), 1);
    // Handshake 16 while releasing 20: 17 must come first.
    applyStimulus(1'b0, 4'b0010, 4'b0010, 0, 20, 0, 0);
    checkOutput("same-cycle idx1", int'(bus.alloc_idx[1]), 17);
    checkOutput("same-cycle cnt1", int'(free_cnt[1]), 1);
    applyStimulus(1'b0, 4'b0010, 4'b0000, 0, 0, 0, 0);
    checkOutput("same-cycle next idx1", int'(bus.alloc_idx[1]), 20);
    checkOutput("same-cycle next cnt1", int'(free_cnt[1]), 0);

    // Illegal releases: wrong partition (ch0), already free (ch2), reserved (ch3).
    applyStimulus(1'b0, 4'b0000, 4'b1101, 40, 0, 40, 48);
    checkOutput("illegal err", int'(err_illegal_rel), 4'b1101);
    checkOutput("illegal cnt0", int'(free_cnt[0]), 0);
    checkOutput("illegal cnt2", int'(free_cnt[2]), 15);
    checkOutput("illegal cnt3", int'(free_cnt[3]), 15);
    checkOutput("illegal idx3", int'(bus.alloc_idx[3]), 48);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    checkOutput("sticky err", int'(err_illegal_rel), 4'b1101);

    // Reset in the middle of traffic.
    applyStimulus(1'b1, 4'b1111, 4'b1111, 5, 20, 33, 49);
    checkAllReset("mid reset");
    applyStimulus(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    checkAllFresh("restart");
    applyStimulus(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_cache_wdb_entry_alloc.md
# vec_cache_wdb_entry_alloc

Write-data-buffer (WDB) entry allocator. It sits directly upstream of the write request crossbar and drives that crossbar's `alloc_vld` / `alloc_idx` / `alloc_rdy` channels. It keeps one free list per crossbar output channel (4 channels), pre-reserves one free entry index per channel, and returns entries to the free list when the downstream data path releases them after the buffered write data is consumed.

## Interface

Parameters:
- `DB_ENTRY_NUM`, default 64: total WDB entries.
  - Must equal 4·2^k with k≥1.
  - `$clog2(DB_ENTRY_NUM)` must equal `DB_ENTRY_IDX_WIDTH` from `vector_cache_pkg`.
- `E` (localparam) = `DB_ENTRY_NUM/4`: entries owned by each channel. Channel c owns global indices c·E … c·E+E−1.

Ports:
- `clk`  in  1  — clock; all state updates on the rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `alloc_vld`  out  4  — channel c holds a reserved free entry.
- `alloc_idx`  out  `DB_ENTRY_IDX_WIDTH` ×4  — global index of the reserved entry.
- `alloc_rdy`  in  4  — consumer takes the entry; the handshake completes when `alloc_vld[c] && alloc_rdy[c]`.
- `rel_vld`  in  4  — release request on channel c.
- `rel_idx`  in  `DB_ENTRY_IDX_WIDTH` ×4  — global index being released on channel c.
- `free_cnt`  out  `$clog2(E+1)` ×4  — number of free entries in channel c's map. The reserved output entry is not counted.
- `err_illegal_rel`  out  4  — sticky flag: channel c received an illegal release.

## Operation

- **Per-channel state:**
  - `free_q[c][E-1:0]`: bit i = 1 means local entry i is free.
  - Output register: `alloc_vld_q[c]` and `alloc_idx_q[c]`.
  - Sticky error bit per channel.
- **Reserve (load) condition:** the output register is loadable when `!alloc_vld_q[c] || alloc_rdy[c]`.
  - If loadable and `free_q[c]` is non-zero: pick the lowest set bit i, clear `free_q[c][i]`, and load `alloc_idx_q = c·E + i`, `alloc_vld_q = 1`.
  - If loadable and `free_q[c]` is zero: `alloc_vld_q` ← 0.
  - A reserved entry is busy; it is never in the free map.
- **Consume:** the handshake itself changes no free-map state, because the entry was already removed at reserve time.
- **Release:** on `rel_vld[c]`, let `i = rel_idx[c] − c·E`. The release is legal only when all of the following hold:
  - `rel_idx[c]` lies in channel c's partition;
  - `free_q[c][i] == 0`;
  - `!(alloc_vld_q[c] && rel_idx[c] == alloc_idx_q[c])`.
- **Legal release:** set `free_q[c][i]` at the edge.
- **Illegal release:** no state change except `err_illegal_rel[c]` ← 1. The flag is cleared only by `rst`.
- **Same-cycle reserve and release:** the reserve picks from the registered `free_q` before the release is applied. The released entry is not a candidate until the next cycle.
- **`free_cnt[c]`:** the registered popcount of `free_q[c]`, updated in the same edge as `free_q`. It never exceeds E.
- **Channel independence:** channels share no state.

## Timing

- **Reset** (`rst` high at an edge), all outputs:
  - `free_q` = all ones;
  - `alloc_vld` = 0, `alloc_idx` = 0;
  - `free_cnt` = E;
  - `err_illegal_rel` = 0.
- **First cycle after reset deasserts:** the outputs are loadable, so at that edge `alloc_vld` = 4'b1111, `alloc_idx[c]` = c·E, and `free_cnt` = E−1.
  - `alloc_vld` is therefore high in the 2nd cycle after `rst` falls.
- **Throughput:** one allocation per channel per cycle while free entries remain. On a handshake, the next index is presented in the following cycle with no bubble.
- **`alloc_vld` / `alloc_idx` stability:** both are driven directly from flops.
  - `alloc_idx` holds stable while `alloc_vld && !alloc_rdy`.
  - `alloc_vld` never drops without a handshake, except on `rst`.
- **Release-to-reserve latency when the channel is empty:** release at cycle t → `free_q` set at the end of t → reserved at the end of t+1 → `alloc_vld` high in cycle t+2.
- **`rst` asserted mid-operation:** all reservations and busy entries are discarded. A pending handshake in the same cycle is lost; the consumer must also be reset.

## Test plan

- **Reset, then idle:** assert `rst` for 2 cycles with `alloc_rdy` = 0 → one cycle after deassert, `alloc_idx` = {48, 32, 16, 0}, `alloc_vld` = 4'hF, `free_cnt` = 15 each. Values hold while `alloc_rdy` stays 0.
- **Drain channel 0:** hold `alloc_rdy[0]` = 1 → indices 0,1,…,15 on consecutive cycles. After the 16th handshake, `alloc_vld[0]` = 0 and `free_cnt[0]` = 0. Other channels are unchanged.
- **Refill:** with channel 0 drained, release idx 5 at cycle t → `alloc_vld[0]` = 1 with `alloc_idx[0]` = 5 in cycle t+2. `free_cnt[0]` shows 1 in t+1 and 0 in t+2.
- **Same-cycle reserve and release, channel 1:** `free_q` = {17 free only}, output holds 16, handshake 16 while releasing 20 at cycle t → cycle t+1 shows idx 17. The next handshake gives idx 20 (not 20 first).
- **Illegal releases, one per run:**
  - idx 40 on channel 0 (wrong partition);
  - a currently free index;
  - the currently reserved `alloc_idx`;
  
  each → `err_illegal_rel[c]` = 1 from the next cycle, `free_q` / `free_cnt` unchanged, and the flag stays set until `rst`.
- **Reset mid-stream:** all channels busy with releases in flight, assert `rst` → next cycle all outputs equal their reset values. One cycle after deassert, the indices restart at c·E.
